// File: rtl/stbuf_pkg.sv
// Shared types and defaults for the store buffer slice.
package stbuf_pkg;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
  } sb_entry_t;

  localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/stbuf_match.sv
// Youngest-first priority matcher: finds the most recently pushed valid
// entry whose word address equals the lookup address.
module stbuf_match
  import stbuf_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PW = $clog2(DEPTH)
) (
  input  sb_entry_t         entries [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PW-1:0]     tail,
  input  logic [29:0]       addr,
  output logic              hit,
  output logic [31:0]       data
);

  logic [PW-1:0] idx;

  // Walk from oldest slot (tail) to youngest (tail-1) so the youngest match wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned k = DEPTH; k >= 1; k--) begin
      idx = tail - PW'(k);
      if (valid[idx] && entries[idx].waddr == addr) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between core data port and handshaked memory write channel,
// with load forwarding. Optional STBUF_STATS_EN adds store/stall counters.
module store_buffer
  import stbuf_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      MemWrite,
  input  logic [31:0]               ALUResult,
  input  logic [31:0]               WriteData,
  output logic [31:0]               ReadData,
  output logic                      StoreStall,
  output logic                      mem_wvalid,
  input  logic                      mem_wready,
  output logic [31:0]               mem_waddr,
  output logic [31:0]               mem_wdata,
  output logic [31:0]               mem_raddr,
  input  logic [31:0]               mem_rdata,
  output logic [$clog2(DEPTH):0]    sb_count,
  output logic                      sb_empty
`ifdef STBUF_STATS_EN
  ,
  output logic [31:0]               stat_stores,
  output logic [31:0]               stat_stalls
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t        entries [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    off;
  logic             full, push, pop, hit;
  logic [31:0]      fwd_data;

  assign full       = (count == CW'(DEPTH));
  assign sb_count   = count;
  assign sb_empty   = (count == '0);
  assign mem_wvalid = !sb_empty;
  assign StoreStall = MemWrite && full && !mem_wready;
  assign push       = MemWrite && !StoreStall;
  assign pop        = mem_wvalid && mem_wready;
  assign mem_waddr  = {entries[head].waddr, 2'b00};
  assign mem_wdata  = entries[head].data;
  assign mem_raddr  = ALUResult & ~32'h3;

  // Occupied slots are the count entries starting at head, modulo DEPTH.
  always_comb begin
    valid = '0;
    off   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - head;
      valid[i] = (CW'(off) < count);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // When full with a simultaneous pop, tail == head: the retiring slot is reused.
  always_ff @(posedge clk) begin
    if (push) entries[tail] <= {ALUResult[31:2], WriteData};
  end

  stbuf_match #(.DEPTH(DEPTH)) u_match (
    .entries (entries),
    .valid   (valid),
    .tail    (tail),
    .addr    (mem_raddr[31:2]),
    .hit     (hit),
    .data    (fwd_data)
  );

  assign ReadData = hit ? fwd_data : mem_rdata;

`ifdef STBUF_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stores <= '0;
      stat_stalls <= '0;
    end else begin
      if (push && stat_stores != '1)       stat_stores <= stat_stores + 1'b1;
      if (StoreStall && stat_stalls != '1) stat_stalls <= stat_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer against a queue-based reference model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult, WriteData, ReadData;
  logic        StoreStall, mem_wvalid, mem_wready;
  logic [31:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;
  logic [2:0]  sb_count;
  logic        sb_empty;
`ifdef STBUF_STATS_EN
  logic [31:0] stat_stores, stat_stalls;
`endif

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .StoreStall (StoreStall),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .sb_count   (sb_count),
    .sb_empty   (sb_empty)
`ifdef STBUF_STATS_EN
    ,
    .stat_stores(stat_stores),
    .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_stores, m_stalls;

  function automatic logic exp_stall();
    return MemWrite && q.size() == DEPTH && !mem_wready;
  endfunction

  function automatic logic [31:0] exp_read();
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a == ALUResult[31:2]) return q[i].d;
    return mem_rdata;
  endfunction

  task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] d,
                       input logic wr, input logic [31:0] rd);
    MemWrite = mw; ALUResult = a; WriteData = d; mem_wready = wr; mem_rdata = rd;
    #1;
  endtask

  // Advance one clock and apply the same edge to the reference model.
  task automatic tick();
    logic st, pu, po;
    ent_t e;
    st = exp_stall();
    pu = MemWrite && !st;
    po = (q.size() > 0) && mem_wready;
    e.a = ALUResult[31:2];
    e.d = WriteData;
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      m_stores = '0;
      m_stalls = '0;
    end else begin
      if (po) void'(q.pop_front());
      if (pu) q.push_back(e);
      if (pu && m_stores != '1) m_stores = m_stores + 1;
      if (st && m_stalls != '1) m_stalls = m_stalls + 1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", sb_count); end
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", sb_empty); end
    checks++; if (mem_wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid got=%b exp=0", mem_wvalid); end
    checks++; if (StoreStall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", StoreStall); end
  endtask

  task automatic test_push_latency();
    do_reset();
    drive(1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0);
    checks++; if (mem_wvalid !== 1'b0) begin errors++; $display("FAIL push_no_bypass got=%b exp=0", mem_wvalid); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    checks++; if (mem_wvalid !== 1'b1) begin errors++; $display("FAIL push_wvalid got=%b exp=1", mem_wvalid); end
    checks++; if (mem_waddr !== 32'h100) begin errors++; $display("FAIL push_waddr got=%h exp=00000100", mem_waddr); end
    checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL push_wdata got=%h exp=deadbeef", mem_wdata); end
    checks++; if (sb_count !== 3'd1) begin errors++; $display("FAIL push_count got=%0d exp=1", sb_count); end
  endtask

  task automatic test_forwarding();
    do_reset();
    drive(1'b1, 32'h20, 32'h11, 1'b0, 32'h0); tick();
    drive(1'b1, 32'h20, 32'h22, 1'b0, 32'h0); tick();
    drive(1'b0, 32'h22, 32'h0, 1'b0, 32'h99);
    checks++; if (ReadData !== 32'h22) begin errors++; $display("FAIL fwd_youngest got=%h exp=00000022", ReadData); end
    checks++; if (mem_raddr !== 32'h20) begin errors++; $display("FAIL fwd_raddr got=%h exp=00000020", mem_raddr); end
    drive(1'b0, 32'h24, 32'h0, 1'b0, 32'h99);
    checks++; if (ReadData !== 32'h99) begin errors++; $display("FAIL fwd_miss got=%h exp=00000099", ReadData); end
  endtask

  task automatic test_full_stall();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h40 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 32'h0);
      tick();
    end
    drive(1'b1, 32'h80, 32'h555, 1'b0, 32'h0);
    checks++; if (StoreStall !== 1'b1) begin errors++; $display("FAIL full_stall got=%b exp=1", StoreStall); end
    tick();
    checks++; if (sb_count !== 3'd4) begin errors++; $display("FAIL full_count_stalled got=%0d exp=4", sb_count); end
    // Store to the popping head's address: the retiring entry still forwards.
    drive(1'b1, 32'h40, 32'h555, 1'b1, 32'h0);
    checks++; if (StoreStall !== 1'b0) begin errors++; $display("FAIL full_pop_stall got=%b exp=0", StoreStall); end
    checks++; if (ReadData !== 32'hA0) begin errors++; $display("FAIL pop_forward got=%h exp=000000a0", ReadData); end
    tick();
    checks++; if (sb_count !== 3'd4) begin errors++; $display("FAIL full_pop_count got=%0d exp=4", sb_count); end
  endtask

  task automatic test_drain();
    logic [31:0] exp_a [4];
    exp_a[0] = 32'h44; exp_a[1] = 32'h48; exp_a[2] = 32'h4C; exp_a[3] = 32'h40;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
      checks++; if (mem_waddr !== exp_a[i] || mem_wvalid !== 1'b1) begin
        errors++; $display("FAIL drain_order[%0d] got=%h/%b exp=%h/1", i, mem_waddr, mem_wvalid, exp_a[i]);
      end
      tick();
    end
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", sb_empty); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 32'h700 + 32'(i), 1'b0, 32'h0);
      tick();
    end
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h304, 32'h0, 1'b0, 32'hABCD);
    checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", sb_count); end
    checks++; if (mem_wvalid !== 1'b0) begin errors++; $display("FAIL midrst_wvalid got=%b exp=0", mem_wvalid); end
    checks++; if (ReadData !== 32'hABCD) begin errors++; $display("FAIL midrst_read got=%h exp=0000abcd", ReadData); end
  endtask

`ifdef STBUF_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i), 32'(i), 1'b0, 32'h0);
      tick();
    end
    drive(1'b1, 32'h600, 32'h6, 1'b0, 32'h0); tick();
    tick();
    drive(1'b1, 32'h600, 32'h6, 1'b1, 32'h0); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    checks++; if (stat_stores !== 32'd5) begin errors++; $display("FAIL stat_stores got=%0d exp=5", stat_stores); end
    checks++; if (stat_stalls !== 32'd2) begin errors++; $display("FAIL stat_stalls got=%0d exp=2", stat_stalls); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] a;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      a = {25'h0, 3'($urandom_range(0, 7)), 2'b00, 2'($urandom)};
      drive(1'($urandom_range(0, 2) != 0), a, $urandom, 1'($urandom_range(0, 2) == 0), $urandom);
      checks++; if (StoreStall !== exp_stall()) begin errors++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", n, StoreStall, exp_stall()); end
      checks++; if (ReadData !== exp_read()) begin errors++; $display("FAIL rnd_read[%0d] got=%h exp=%h", n, ReadData, exp_read()); end
      checks++; if (int'(sb_count) !== q.size() || sb_empty !== (q.size() == 0) || mem_wvalid !== (q.size() != 0)) begin
        errors++; $display("FAIL rnd_count[%0d] got=%0d/%b/%b exp=%0d", n, sb_count, sb_empty, mem_wvalid, q.size());
      end
      if (q.size() != 0) begin
        checks++; if (mem_waddr !== {q[0].a, 2'b00} || mem_wdata !== q[0].d) begin
          errors++; $display("FAIL rnd_head[%0d] got=%h:%h exp=%h:%h", n, mem_waddr, mem_wdata, {q[0].a, 2'b00}, q[0].d);
        end
      end
      tick();
    end
    reset = 1'b0;
`ifdef STBUF_STATS_EN
    checks++; if (stat_stores !== m_stores || stat_stalls !== m_stalls) begin
      errors++; $display("FAIL rnd_stats got=%0d/%0d exp=%0d/%0d", stat_stores, stat_stalls, m_stores, m_stalls);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    m_stores = '0;
    m_stalls = '0;
    test_reset();
    test_push_latency();
    test_forwarding();
    test_full_stall();
    test_drain();
    test_reset_midop();
`ifdef STBUF_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the single-cycle core's data port and a handshaked data-memory bus. It takes word stores issued by the core (MemWrite, ALUResult, WriteData) into a FIFO and drains them to memory through a valid/ready write channel. It returns ReadData to the core combinationally, forwarding from the youngest buffered store that matches the load address, so loads never observe stale memory. It sits directly downstream of the core and upstream of data memory.

## Interface
- DEPTH, 4, number of buffered stores; power of two, ≥2
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- MemWrite  in  1  core store strobe for this cycle
- ALUResult  in  32  core data address; bits [1:0] ignored
- WriteData  in  32  core store data
- ReadData  out  32  load data to core, combinational
- StoreStall  out  1  store not accepted this cycle; the integrator holds the core
- mem_wvalid  out  1  head entry valid on the write channel
- mem_wready  in  1  memory accepts the head entry at this edge
- mem_waddr  out  32  head word address, {addr[31:2],2'b00}
- mem_wdata  out  32  head data
- mem_raddr  out  32  {ALUResult[31:2],2'b00}, combinational
- mem_rdata  in  32  memory read data for mem_raddr, combinational
- sb_count  out  $clog2(DEPTH)+1  entries held
- sb_empty  out  1  sb_count==0

## Operation
- Storage: DEPTH entries of {word address [29:0], data [31:0]}; head/tail pointers plus a count.
- Push: MemWrite && !StoreStall writes {ALUResult[31:2], WriteData} at tail.
- Pop: mem_wvalid && mem_wready retires head.
- mem_wvalid = !sb_empty; mem_waddr and mem_wdata driven from head; both held stable while mem_wready is low.
- StoreStall = MemWrite && full && !mem_wready. When full, a simultaneous pop frees the slot, so the push is accepted.
- Forwarding: compare ALUResult[31:2] against every valid entry. On a match, ReadData = data of the youngest matching entry, closest to tail. With no match, ReadData = mem_rdata. ReadData is driven regardless of instruction type; the core ignores it on non-loads.
- An entry popping at the current edge still forwards during that cycle.
- Pointers wrap modulo DEPTH. Count goes +1 on push only, −1 on pop only, and is unchanged when both occur.
- Ordering: strict FIFO. Repeated stores to one address are not merged.

## Timing
- Reset values: sb_count=0, sb_empty=1, mem_wvalid=0, StoreStall=0 unless MemWrite is asserted while full. Pointers are 0. Data contents are don't-care.
- Push-to-mem_wvalid latency: 1 cycle. There is no same-cycle bypass into an empty buffer.
- A store accepted at edge N is forwardable to a load in cycle N+1 onward.
- Combinational paths: mem_wready→StoreStall and ALUResult/mem_rdata→ReadData.
- Reset mid-operation discards all buffered stores; nothing further is presented on the write channel.
- Empty: pop is impossible; mem_wready is ignored.

## Configuration
- STBUF_STATS_EN defined adds outputs stat_stores[31:0] (accepted pushes) and stat_stalls[31:0] (cycles with StoreStall=1).
- Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: the ports and counters are absent. Functional behaviour is identical either way.

## Structure
- Package stbuf_pkg: typedef sb_entry_t {logic [29:0] waddr; logic [31:0] data;} and localparam DEFAULT_DEPTH=4.
- One sub-module, stbuf_match: a youngest-first priority matcher taking the entry array, valid mask, tail pointer and lookup address, and returning hit and data.
- FIFO control lives in store_buffer.

## Test plan
- Reset, then MemWrite with ALUResult=0x100, WriteData=0xDEADBEEF and mem_wready=0 → next cycle mem_wvalid=1, mem_waddr=0x100, mem_wdata=0xDEADBEEF, sb_count=1.
- Stores 0x20←0x11 then 0x20←0x22 with mem_wready=0, then load ALUResult=0x22 with mem_rdata=0x99 → ReadData=0x22 (youngest, low bits ignored). Load 0x24 → ReadData=0x99.
- Fill 4 entries with mem_wready=0, then MemWrite → StoreStall=1 and count stays 4. Same cycle with mem_wready=1 → StoreStall=0 and count stays 4.
- Drain 4 entries with mem_wready=1 every cycle → addresses appear in push order, one per cycle, and sb_empty=1 after the fourth.
- Assert reset with 3 entries held → next cycle sb_count=0 and mem_wvalid=0. A load of a previously buffered address returns mem_rdata.
- With STBUF_STATS_EN defined: 5 pushes and 2 stall cycles → stat_stores=5, stat_stalls=2.
